uart_reg_reporter: RTL and testbench
====================================

# uart_reg_reporter

Readback side of the UART register-control path. On a query request it snapshots one PWM/DAC channel's configuration and status registers, frames them into a fixed 14-byte response packet with header and checksum, and streams the bytes to the UART byte transmitter over a valid/ready handshake. It sits between the register mapper's register file and the UART TX serializer, in the clk_50M domain.

## Interface

Parameters:
- _NUM_CHANNELS, 3, number of pattern channels; channel index _NUM_CHANNELS is the slow (level-only) channel.

Ports:
- clk_50M  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  1  query request.
- req_ready  output  1  high when idle and able to accept a request.
- req_func  input  8  function code, echoed in the frame.
- req_ch  input  8  channel index to report.
- duty_num_bus  input  8*_NUM_CHANNELS  channel i at bits [8i+7:8i].
- pulse_dessert_bus  input  16*_NUM_CHANNELS  channel i at [16i+15:16i].
- pulse_num_bus  input  8*_NUM_CHANNELS  per channel.
- pat_bus  input  32*_NUM_CHANNELS  per channel.
- ctrl_sta_bus  input  8*(_NUM_CHANNELS+1)  low-speed control byte per channel, including the slow channel.
- pwm_busy  input  _NUM_CHANNELS  per-channel busy.
- pwm_valid  input  _NUM_CHANNELS  per-channel valid.
- tx_data  output  8  byte to UART TX.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  UART TX accepts the byte.
- frame_done  output  1  one-cycle pulse after the last byte is accepted.

## Operation

- States: IDLE, SEND.
- IDLE: req_ready=1, tx_valid=0. On req_valid, the captured fields are registered on the same edge, the byte index is set to 0, and the block moves to SEND. The request inputs are not used after capture.
- Capture rules, with ch = req_ch:
  - ch < _NUM_CHANNELS:
    - status = {5'b0, pwm_valid[ch], pwm_busy[ch], ctrl_sta[ch][0]}.
    - All data fields come from channel ch.
  - ch == _NUM_CHANNELS: status = {7'b0, ctrl_sta[ch][0]}; all data fields are 0.
  - ch > _NUM_CHANNELS: status = 8'h80 (error); all data fields are 0.
- Frame bytes, in index order 0..13:
  - 0x55, 0xAA, func, ch, status.
  - duty, pd[15:8], pd[7:0], pnum.
  - PAT[31:24], PAT[23:16], PAT[15:8], PAT[7:0].
  - csum.
- csum = 8-bit wrap-around sum of bytes 2..12. Headers are excluded.
- SEND:
  - tx_data shows the byte for the current index and tx_valid=1.
  - When tx_valid && tx_ready, the index increments.
  - When index 13 is accepted: frame_done=1 for one cycle, state returns to IDLE, tx_valid=0.
- req_valid during SEND is ignored (req_ready=0). No queueing.

## Timing

- Reset values:
  - tx_valid=0, tx_data=8'h00, frame_done=0.
  - req_ready=1, state IDLE, index 0, capture registers 0.
- Request accepted at edge N: tx_valid=1 with byte 0 (0x55) from cycle N+1.
- Byte throughput: with tx_ready held high, one byte per cycle. The frame spans cycles N+1..N+14; frame_done is high in cycle N+15; req_ready is high in cycle N+15.
- Throttling: tx_data and tx_valid are held stable while tx_ready=0. The next byte appears the cycle after acceptance.
- tx_valid never drops mid-frame.
- Snapshot isolation: changes on the register buses after capture do not affect the frame in flight.
- Reset mid-frame aborts immediately to reset values: no frame_done, and the partial frame is not resumed.

## Test plan

- Channel 0 readback, _NUM_CHANNELS=3, tx_ready=1:
  - Setup: func 0x81; ch0 duty=0x10, pd=0x0100, pnum=0x05, PAT=0x0000000F, ctrl bit0=1, busy=1, valid=0.
  - Required bytes: 55 AA 81 00 03 10 01 00 05 00 00 00 0F A9, in 14 consecutive cycles, then one frame_done pulse.
- Throttling: same request with tx_ready toggled 1/0 each cycle (and a 5-cycle low stall) → identical byte sequence; tx_data stable while stalled; frame_done only after byte 13 is accepted.
- Slow channel: func 0x82, ch 3, ctrl_sta[3]=0x01 → 55 AA 82 03 01 00×8 86.
- Invalid channel: func 0x81, ch 0x07 → 55 AA 81 07 80 00×8 08.
- Busy and snapshot checks:
  - A second req_valid during SEND is ignored, req_ready=0, and exactly one frame is sent.
  - Changing pat_bus mid-frame does not alter the transmitted PAT bytes.
- Reset mid-frame: assert rst_n low at byte 6 → tx_valid=0 asynchronously, no frame_done. After release, req_ready=1, and a new request yields a full correct frame starting at 0x55.

Source files
------------

// File: rtl/uart_reg_reporter.sv
// Register readback framer: snapshots one channel's config/status on a query and
// streams a 14-byte response frame (55 AA header, payload, checksum) over valid/ready.
module uart_reg_reporter #(
    parameter int _NUM_CHANNELS = 3
) (
    input  logic                            clk_50M,
    input  logic                            rst_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [7:0]                      req_func,
    input  logic [7:0]                      req_ch,
    input  logic [8*_NUM_CHANNELS-1:0]      duty_num_bus,
    input  logic [16*_NUM_CHANNELS-1:0]     pulse_dessert_bus,
    input  logic [8*_NUM_CHANNELS-1:0]      pulse_num_bus,
    input  logic [32*_NUM_CHANNELS-1:0]     pat_bus,
    input  logic [8*(_NUM_CHANNELS+1)-1:0]  ctrl_sta_bus,
    input  logic [_NUM_CHANNELS-1:0]        pwm_busy,
    input  logic [_NUM_CHANNELS-1:0]        pwm_valid,
    output logic [7:0]                      tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic                            frame_done
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SEND  = 1'b1;
    localparam logic [3:0] LAST_IDX = 4'd13;

    logic [0:0]  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  func_q, func_d;
    logic [7:0]  ch_q, ch_d;
    logic [7:0]  status_q, status_d;
    logic [7:0]  duty_q, duty_d;
    logic [15:0] pd_q, pd_d;
    logic [7:0]  pnum_q, pnum_d;
    logic [31:0] pat_q, pat_d;
    logic        done_q, done_d;

    logic [7:0]  cap_status;
    logic [7:0]  cap_duty;
    logic [15:0] cap_pd;
    logic [7:0]  cap_pnum;
    logic [31:0] cap_pat;
    logic        accept;
    logic        fire;
    logic [7:0]  csum;
    logic [7:0]  frame_byte;

    // Out-of-range channels default to the error status with zeroed data.
    always_comb begin
        cap_status = 8'h80;
        cap_duty   = 8'h00;
        cap_pd     = 16'h0000;
        cap_pnum   = 8'h00;
        cap_pat    = 32'h0000_0000;
        if (req_ch == 8'(_NUM_CHANNELS)) begin
            cap_status = {7'b0, ctrl_sta_bus[8*_NUM_CHANNELS]};
        end
        for (int i = 0; i < _NUM_CHANNELS; i++) begin
            if (req_ch == 8'(i)) begin
                cap_status = {5'b0, pwm_valid[i], pwm_busy[i], ctrl_sta_bus[8*i]};
                cap_duty   = duty_num_bus[8*i +: 8];
                cap_pd     = pulse_dessert_bus[16*i +: 16];
                cap_pnum   = pulse_num_bus[8*i +: 8];
                cap_pat    = pat_bus[32*i +: 32];
            end
        end
    end

    assign accept = (state_q == ST_IDLE) && req_valid;
    assign fire   = (state_q == ST_SEND) && tx_ready;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        func_d   = func_q;
        ch_d     = ch_q;
        status_d = status_q;
        duty_d   = duty_q;
        pd_d     = pd_q;
        pnum_d   = pnum_q;
        pat_d    = pat_q;
        done_d   = fire && (idx_q == LAST_IDX);
        if (accept) begin
            state_d  = ST_SEND;
            idx_d    = 4'd0;
            func_d   = req_func;
            ch_d     = req_ch;
            status_d = cap_status;
            duty_d   = cap_duty;
            pd_d     = cap_pd;
            pnum_d   = cap_pnum;
            pat_d    = cap_pat;
        end else if (fire) begin
            if (idx_q == LAST_IDX) begin
                state_d = ST_IDLE;
                idx_d   = 4'd0;
            end else begin
                idx_d = idx_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= 4'd0;
            func_q   <= 8'h00;
            ch_q     <= 8'h00;
            status_q <= 8'h00;
            duty_q   <= 8'h00;
            pd_q     <= 16'h0000;
            pnum_q   <= 8'h00;
            pat_q    <= 32'h0000_0000;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            func_q   <= func_d;
            ch_q     <= ch_d;
            status_q <= status_d;
            duty_q   <= duty_d;
            pd_q     <= pd_d;
            pnum_q   <= pnum_d;
            pat_q    <= pat_d;
            done_q   <= done_d;
        end
    end

    // Checksum covers func through PAT[7:0]; the two header bytes are excluded.
    assign csum = func_q + ch_q + status_q + duty_q + pd_q[15:8] + pd_q[7:0] + pnum_q
                + pat_q[31:24] + pat_q[23:16] + pat_q[15:8] + pat_q[7:0];

    always_comb begin
        case (idx_q)
            4'd0:    frame_byte = 8'h55;
            4'd1:    frame_byte = 8'hAA;
            4'd2:    frame_byte = func_q;
            4'd3:    frame_byte = ch_q;
            4'd4:    frame_byte = status_q;
            4'd5:    frame_byte = duty_q;
            4'd6:    frame_byte = pd_q[15:8];
            4'd7:    frame_byte = pd_q[7:0];
            4'd8:    frame_byte = pnum_q;
            4'd9:    frame_byte = pat_q[31:24];
            4'd10:   frame_byte = pat_q[23:16];
            4'd11:   frame_byte = pat_q[15:8];
            4'd12:   frame_byte = pat_q[7:0];
            default: frame_byte = csum;
        endcase
    end

    assign tx_valid   = (state_q == ST_SEND);
    assign tx_data    = (state_q == ST_SEND) ? frame_byte : 8'h00;
    assign req_ready  = (state_q == ST_IDLE);
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_reg_reporter.sv
// Self-checking bench for uart_reg_reporter: a queue-based frame model checked every
// cycle, plus literal frames for the directed readback, slow and invalid channel cases.
module tb_uart_reg_reporter;

    localparam int NCH = 3;

    logic              clk_50M = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [7:0]        req_func = 8'h00;
    logic [7:0]        req_ch = 8'h00;
    logic [8*NCH-1:0]  duty_num_bus = '0;
    logic [16*NCH-1:0] pulse_dessert_bus = '0;
    logic [8*NCH-1:0]  pulse_num_bus = '0;
    logic [32*NCH-1:0] pat_bus = '0;
    logic [8*NCH+7:0]  ctrl_sta_bus = '0;
    logic [NCH-1:0]    pwm_busy = '0;
    logic [NCH-1:0]    pwm_valid = '0;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b1;
    logic              frame_done;

    uart_reg_reporter #(._NUM_CHANNELS(NCH)) dut (
        .clk_50M(clk_50M), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_func(req_func), .req_ch(req_ch),
        .duty_num_bus(duty_num_bus), .pulse_dessert_bus(pulse_dessert_bus),
        .pulse_num_bus(pulse_num_bus), .pat_bus(pat_bus),
        .ctrl_sta_bus(ctrl_sta_bus), .pwm_busy(pwm_busy), .pwm_valid(pwm_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .frame_done(frame_done)
    );

    always #10 clk_50M = ~clk_50M;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;
    logic [7:0] got[$];
    int         done_cnt = 0;
    int         tx_mode = 0;
    int         cyc = 0;
    logic [7:0] exp_f [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Whole expected frame from the register values present when the request is taken.
    function automatic void load_frame(input logic [7:0] f, input logic [7:0] c);
        int         ci;
        logic [7:0] st, du, pn, s;
        logic [15:0] pd;
        logic [31:0] pt;
        logic [7:0] b [14];
        ci = int'(c);
        st = 8'h80; du = 8'h00; pd = 16'h0; pn = 8'h00; pt = 32'h0;
        if (ci < NCH) begin
            st = {5'b0, pwm_valid[ci], pwm_busy[ci], ctrl_sta_bus[8*ci]};
            du = duty_num_bus[8*ci +: 8];
            pd = pulse_dessert_bus[16*ci +: 16];
            pn = pulse_num_bus[8*ci +: 8];
            pt = pat_bus[32*ci +: 32];
        end else if (ci == NCH) begin
            st = {7'b0, ctrl_sta_bus[8*NCH]};
        end
        b = '{8'h55, 8'hAA, f, c, st, du, pd[15:8], pd[7:0], pn,
              pt[31:24], pt[23:16], pt[15:8], pt[7:0], 8'h00};
        s = 8'h00;
        for (int i = 2; i <= 12; i++) s = s + b[i];
        b[13] = s;
        for (int i = 0; i < 14; i++) exp_q.push_back(b[i]);
    endfunction

    initial forever begin
        @(posedge clk_50M or negedge rst_n);
        if (!rst_n) begin
            exp_q.delete();
            m_busy = 1'b0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (tx_ready) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end else if (req_valid) begin
                load_frame(req_func, req_ch);
                m_busy = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk_50M);
        #1;
        chk("tx_valid", 32'(tx_valid), 32'(m_busy));
        if (m_busy) chk("tx_data", 32'(tx_data), 32'(exp_q[0]));
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("req_ready", 32'(req_ready), 32'(!m_busy));
    end

    initial forever begin
        @(negedge clk_50M);
        #1;
        if (rst_n && tx_valid && tx_ready) got.push_back(tx_data);
        if (rst_n && frame_done) done_cnt++;
    end

    initial forever begin
        @(negedge clk_50M);
        cyc++;
        case (tx_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ((cyc % 16) inside {[3:7]}) ? 1'b0 : cyc[0];
            2:       tx_ready = ($urandom_range(0, 3) != 0);
            default: tx_ready = 1'b1;
        endcase
    end

    task automatic rnd_bus();
        duty_num_bus      = 24'($urandom);
        pulse_dessert_bus = 48'({$urandom, $urandom});
        pulse_num_bus     = 24'($urandom);
        pat_bus           = {$urandom, $urandom, $urandom};
        ctrl_sta_bus      = $urandom;
        pwm_busy          = 3'($urandom);
        pwm_valid         = 3'($urandom);
    endtask

    task automatic directed_bus();
        duty_num_bus      = {8'h22, 8'h11, 8'h10};
        pulse_dessert_bus = {16'hBEEF, 16'h1234, 16'h0100};
        pulse_num_bus     = {8'h77, 8'h66, 8'h05};
        pat_bus           = {32'hCAFEF00D, 32'hDEADBEEF, 32'h0000000F};
        ctrl_sta_bus      = {8'h01, 8'hFE, 8'hFF, 8'h01};
        pwm_busy          = 3'b001;
        pwm_valid         = 3'b000;
    endtask

    // variant 1 disturbs pat_bus and re-pulses req_valid while the frame is in flight
    task automatic do_req(input logic [7:0] f, input logic [7:0] c, input int variant,
                          output int lat);
        int d0;
        int t;
        d0 = done_cnt;
        got.delete();
        @(negedge clk_50M);
        req_func = f; req_ch = c; req_valid = 1'b1;
        @(negedge clk_50M);
        req_valid = 1'b0;
        t = 0;
        while (done_cnt == d0 && t < 300) begin
            @(negedge clk_50M);
            if (variant == 1) begin
                if (t == 3) pat_bus = {$urandom, $urandom, $urandom};
                req_valid = (t == 4 || t == 5);
                req_func  = 8'h99;
            end
            #2;
            t++;
        end
        req_valid = 1'b0;
        lat = t;
        repeat (3) @(negedge clk_50M);
        #2;
        chk("frames per request", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic check_frame(input string name, input logic [7:0] e [14]);
        chk($sformatf("%s length", name), 32'(got.size()), 32'd14);
        for (int i = 0; i < 14; i++) begin
            if (i < got.size()) chk($sformatf("%s[%0d]", name, i), 32'(got[i]), 32'(e[i]));
        end
    endtask

    initial begin
        int lat;
        int t;
        int d0;
        logic [7:0] f;
        logic [7:0] c;

        #25;
        chk("reset tx_valid", 32'(tx_valid), 32'd0);
        chk("reset tx_data", 32'(tx_data), 32'h00);
        chk("reset frame_done", 32'(frame_done), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        directed_bus();
        @(negedge clk_50M);
        #3 rst_n = 1'b1;

        exp_f = '{8'h55, 8'hAA, 8'h81, 8'h00, 8'h03, 8'h10, 8'h01, 8'h00,
                  8'h05, 8'h00, 8'h00, 8'h00, 8'h0F, 8'hA9};
        tx_mode = 0;
        do_req(8'h81, 8'h00, 0, lat);
        check_frame("ch0", exp_f);
        chk("ch0 done latency", 32'(lat), 32'd14);

        tx_mode = 1;
        do_req(8'h81, 8'h00, 0, lat);
        check_frame("ch0 throttled", exp_f);
        tx_mode = 0;

        exp_f = '{8'h55, 8'hAA, 8'h82, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h86};
        do_req(8'h82, 8'h03, 0, lat);
        check_frame("slow ch", exp_f);

        exp_f = '{8'h55, 8'hAA, 8'h81, 8'h07, 8'h80, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08};
        do_req(8'h81, 8'h07, 0, lat);
        check_frame("bad ch", exp_f);

        directed_bus();
        exp_f = '{8'h55, 8'hAA, 8'h81, 8'h00, 8'h03, 8'h10, 8'h01, 8'h00,
                  8'h05, 8'h00, 8'h00, 8'h00, 8'h0F, 8'hA9};
        do_req(8'h81, 8'h00, 1, lat);
        check_frame("busy+snapshot", exp_f);

        // abort a frame part-way through with an asynchronous reset
        directed_bus();
        d0 = done_cnt;
        got.delete();
        @(negedge clk_50M);
        req_func = 8'h81; req_ch = 8'h00; req_valid = 1'b1;
        @(negedge clk_50M);
        req_valid = 1'b0;
        t = 0;
        while (got.size() < 6 && t < 100) begin
            @(negedge clk_50M);
            #2;
            t++;
        end
        chk("bytes before abort", 32'(got.size()), 32'd6);
        #1 rst_n = 1'b0;
        #1;
        chk("abort tx_valid", 32'(tx_valid), 32'd0);
        chk("abort req_ready", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk_50M);
        #3 rst_n = 1'b1;
        repeat (20) @(negedge clk_50M);
        #2;
        chk("no done after abort", 32'(done_cnt - d0), 32'd0);
        chk("idle after abort", 32'(req_ready), 32'd1);
        do_req(8'h81, 8'h00, 0, lat);
        check_frame("after abort", exp_f);

        tx_mode = 2;
        for (int it = 0; it < 40; it++) begin
            rnd_bus();
            f = 8'($urandom);
            c = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
            @(negedge clk_50M);
            req_func = f; req_ch = c; req_valid = 1'b1;
            @(negedge clk_50M);
            req_valid = 1'b0;
            t = 0;
            while (m_busy && t < 400) begin
                @(negedge clk_50M);
                t++;
                if ($urandom_range(0, 3) == 0) rnd_bus();
                req_valid = m_busy && ($urandom_range(0, 5) == 0);
                req_func  = 8'($urandom);
            end
            req_valid = 1'b0;
            chk("random frame completes", 32'(m_busy), 32'd0);
        end

        repeat (5) @(negedge clk_50M);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
